// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory.
//   size_e   : access size codes carried on the size port
//   state_e  : controller state encoding (CLEAR / IDLE)
//   lane_mask: byte-lane write enables for a given size and byte offset
//   misaligned: illegal-request predicate (bad alignment or size code 3)
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One memory bank: row-addressed storage with per-byte-lane write enables
// and a registered read port.
//   clk_i    : clock
//   rst_ni   : async active-low reset (read register only; contents are not reset)
//   en_i     : access enable for this cycle
//   we_i     : 1 = write selected lanes, 0 = read row into the read register
//   be_i     : byte-lane write enables
//   row_i    : row address
//   wdata_i  : lane-aligned write data
//   rdata_o  : registered read data, holds until the next read
module dmem_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROW_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ROW_W-1:0]    row_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ROW_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        if (be_i[i]) mem_q[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else if (en_i && !we_i) begin
      rd_q <= mem_q[row_i];
    end
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/banked_dmem.sv
// Banked data memory with byte/half/word access, alignment checking,
// load extension and a power-up clear sequence.
//   sys_clk   : clock
//   sys_rst_n : async active-low reset; restarts the clear sequence
//   req/we    : request and store select, accepted when ready is high
//   size      : 0 byte, 1 half, 2 word, 3 illegal
//   sign_ext  : load sign-extension select
//   addr      : byte address
//   wdata     : right-aligned store data
//   ready     : high once the clear has finished
//   rdata     : right-aligned, extended load result (holds between loads)
//   rvalid    : one-cycle pulse, load data valid
//   err       : one-cycle pulse, request rejected
module banked_dmem
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NBANKS = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W+1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned BANK_W = $clog2(NBANKS);
  localparam int unsigned SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int unsigned ROW_W  = ADDR_W - BANK_W;

  state_e            state_q;
  logic [ROW_W-1:0]  clr_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              err_q;
  logic [SEL_W-1:0]  sel_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic              sx_q;

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        off;
  size_e             sz;
  logic              bad;
  logic              accept;
  logic [ROW_W-1:0]  row;
  logic [SEL_W-1:0]  bank_sel;

  assign word_addr = addr[ADDR_W+1:2];
  assign off       = addr[1:0];
  assign sz        = size_e'(size);
  assign bad       = misaligned(sz, off);
  assign accept    = req && ready_q;
  assign row       = word_addr[ROW_W-1:0];

  if (BANK_W > 0) begin : g_sel
    assign bank_sel = word_addr[ADDR_W-1 -: SEL_W];
  end else begin : g_nosel
    assign bank_sel = '0;
  end

  logic                bank_en [NBANKS];
  logic                bank_we;
  logic [DATA_W/8-1:0] bank_be;
  logic [ROW_W-1:0]    bank_row;
  logic [DATA_W-1:0]   bank_wd;
  logic [DATA_W-1:0]   bank_rd [NBANKS];

  // During CLEAR every bank writes zeros to the same row in parallel;
  // otherwise only the addressed bank sees a legal accepted request.
  always_comb begin
    bank_we  = 1'b0;
    bank_be  = '0;
    bank_row = row;
    bank_wd  = '0;
    for (int unsigned b = 0; b < NBANKS; b++) bank_en[b] = 1'b0;
    if (state_q == ST_CLEAR) begin
      bank_we  = 1'b1;
      bank_be  = '1;
      bank_row = clr_q;
      for (int unsigned b = 0; b < NBANKS; b++) bank_en[b] = 1'b1;
    end else if (accept && !bad) begin
      bank_we = we;
      bank_be = lane_mask(sz, off);
      bank_wd = wdata << {off, 3'b000};
      for (int unsigned b = 0; b < NBANKS; b++) begin
        if (SEL_W'(b) == bank_sel) bank_en[b] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    dmem_bank #(
      .DATA_W(DATA_W),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .en_i   (bank_en[g]),
      .we_i   (bank_we),
      .be_i   (bank_be),
      .row_i  (bank_row),
      .wdata_i(bank_wd),
      .rdata_o(bank_rd[g])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_CLEAR;
      clr_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      off_q    <= '0;
      size_q   <= SZ_BYTE;
      sx_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == '1) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            if (bad) begin
              err_q <= 1'b1;
            end else if (!we) begin
              rvalid_q <= 1'b1;
              sel_q    <= bank_sel;
              off_q    <= off;
              size_q   <= sz;
              sx_q     <= sign_ext;
            end
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Load formatting works off the bank read registers plus load attributes
  // captured at acceptance; both only change on an accepted load, so rdata
  // holds its last value between loads.
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;

  always_comb begin
    rd_word  = bank_rd[sel_q];
    rd_shift = rd_word >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: rdata = {{(DATA_W-8){sx_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rdata = {{(DATA_W-16){sx_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rdata = rd_word;
    endcase
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_banked_dmem.sv
module tb_banked_dmem;

  localparam int unsigned K_NONE = 0;
  localparam int unsigned K_LOAD = 1;
  localparam int unsigned K_ERR  = 2;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [11:0] addr;
    logic [31:0] wdata;
    int unsigned kind;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int unsigned kind;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  banked_dmem #(.DATA_W(32), .ADDR_W(10), .NBANKS(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
    end
  endtask

  // Scoreboard monitor: each cycle either the oldest expected response is
  // due, or nothing may come out.
  always @(negedge sys_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.kind == K_LOAD) begin
        check($sformatf("rvalid[%0d]", e.tag), {31'b0, rvalid}, 32'd1);
        check($sformatf("err[%0d]", e.tag), {31'b0, err}, 32'd0);
        check($sformatf("rdata[%0d]", e.tag), rdata, e.exp);
      end else if (e.kind == K_ERR) begin
        check($sformatf("err[%0d]", e.tag), {31'b0, err}, 32'd1);
        check($sformatf("rvalid_on_err[%0d]", e.tag), {31'b0, rvalid}, 32'd0);
      end else begin
        check($sformatf("quiet_store[%0d]", e.tag), {30'b0, rvalid, err}, 32'd0);
      end
    end else begin
      check("quiet", {30'b0, rvalid, err}, 32'd0);
    end
  end

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic x,
                              input logic [11:0] a, input logic [31:0] d,
                              input int unsigned k, input logic [31:0] e);
    vec_t v;
    v.we = w; v.size = s; v.sx = x; v.addr = a; v.wdata = d; v.kind = k; v.exp = e;
    return v;
  endfunction

  // Drive one request at the current (negedge) time, let it be accepted,
  // record what should appear next cycle, and return at the next negedge.
  task automatic send(input vec_t v, input int tag);
    exp_t e;
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wdata;
    @(posedge sys_clk);
    e.kind = v.kind; e.exp = v.exp; e.tag = tag;
    sb.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = '0; wdata = '0;
  endtask

  // Counts rising edges until ready is seen high (bounded); drops req once
  // ready rises so a request held through CLEAR is never accepted.
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    req = 1'b0;
    @(negedge sys_clk);
  endtask

  vec_t vecs[25];
  int n;

  initial begin
    idle_inputs();
    sys_rst_n = 1'b0;
    #1;
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_ready(n);
    check("clear_cycles", n, 32'd256);

    vecs[0]  = mk(0, 2, 0, 12'h3FC, 0,            K_LOAD, 32'h0000_0000);
    vecs[1]  = mk(1, 2, 0, 12'h100, 32'h80FF7F01, K_NONE, 0);
    vecs[2]  = mk(0, 0, 1, 12'h100, 0,            K_LOAD, 32'h0000_0001);
    vecs[3]  = mk(0, 0, 1, 12'h101, 0,            K_LOAD, 32'h0000_007F);
    vecs[4]  = mk(0, 0, 1, 12'h102, 0,            K_LOAD, 32'hFFFF_FFFF);
    vecs[5]  = mk(0, 0, 1, 12'h103, 0,            K_LOAD, 32'hFFFF_FF80);
    vecs[6]  = mk(0, 0, 0, 12'h102, 0,            K_LOAD, 32'h0000_00FF);
    vecs[7]  = mk(0, 0, 0, 12'h103, 0,            K_LOAD, 32'h0000_0080);
    vecs[8]  = mk(1, 2, 0, 12'h008, 32'hAAAAAAAA, K_NONE, 0);
    vecs[9]  = mk(1, 1, 0, 12'h00A, 32'h00001234, K_NONE, 0);
    vecs[10] = mk(0, 2, 0, 12'h008, 0,            K_LOAD, 32'h1234_AAAA);
    vecs[11] = mk(0, 1, 1, 12'h100, 0,            K_LOAD, 32'h0000_7F01);
    vecs[12] = mk(0, 1, 1, 12'h102, 0,            K_LOAD, 32'hFFFF_80FF);
    vecs[13] = mk(0, 1, 0, 12'h102, 0,            K_LOAD, 32'h0000_80FF);
    vecs[14] = mk(1, 2, 0, 12'h000, 32'h11223344, K_NONE, 0);
    vecs[15] = mk(0, 1, 0, 12'h001, 0,            K_ERR,  0);
    vecs[16] = mk(1, 2, 0, 12'h002, 32'hFFFFFFFF, K_ERR,  0);
    vecs[17] = mk(1, 3, 0, 12'h000, 32'hFFFFFFFF, K_ERR,  0);
    vecs[18] = mk(1, 1, 0, 12'h003, 32'hFFFFFFFF, K_ERR,  0);
    vecs[19] = mk(0, 2, 0, 12'h000, 0,            K_LOAD, 32'h1122_3344);
    vecs[20] = mk(1, 2, 0, 12'hFFC, 32'hDEADBEEF, K_NONE, 0);
    vecs[21] = mk(0, 2, 0, 12'hFFC, 0,            K_LOAD, 32'hDEAD_BEEF);
    vecs[22] = mk(1, 0, 0, 12'h005, 32'h0000005A, K_NONE, 0);
    vecs[23] = mk(0, 2, 0, 12'h004, 0,            K_LOAD, 32'h0000_5A00);
    vecs[24] = mk(0, 0, 1, 12'h005, 0,            K_LOAD, 32'h0000_005A);

    for (int i = 0; i < 25; i++) send(vecs[i], i);
    idle_inputs();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rdata_hold", rdata, 32'h0000_005A);
    check("bank3_row255", dut.g_bank[3].u_bank.mem_q[255], 32'hDEAD_BEEF);

    // Reset with a load in flight: no rvalid, clear restarts from row 0.
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 12'hFFC;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    idle_inputs();
    #1;
    check("inflight_rvalid", {31'b0, rvalid}, 32'd0);
    check("inflight_ready", {31'b0, ready}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (100) @(posedge sys_clk);
    #1;
    check("mid_clear_ready", {31'b0, ready}, 32'd0);
    // Reset again at row 100, then hold a store request through the clear.
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 12'h3F8; wdata = 32'hCAFEF00D;
    wait_ready(n);
    check("restart_clear_cycles", n, 32'd256);
    idle_inputs();

    send(mk(0, 2, 0, 12'hFFC, 0, K_LOAD, 32'h0), 100);
    send(mk(0, 2, 0, 12'h100, 0, K_LOAD, 32'h0), 101);
    send(mk(0, 2, 0, 12'h3F8, 0, K_LOAD, 32'h0), 102);
    idle_inputs();
    repeat (3) @(negedge sys_clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_dmem.md
BANKED_DMEM -- requirements
Module: banked_dmem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width; total depth is 2**ADDR_W words.
REQ-003 SHALL have parameter NBANKS, default 4, bank count; power of two, at least 1, and below 2**ADDR_W.
REQ-004 SHALL have ports:
  sys_clk  in  1  single clock; all state changes on its rising edge.
  sys_rst_n  in  1  asynchronous, active-low reset.
  req  in  1  access request; qualified by ready.
  we  in  1  1 = store, 0 = load.
  size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal.
  sign_ext  in  1  load sign-extension select (1 = sign, 0 = zero).
  addr  in  ADDR_W+2  byte address.
  wdata  in  DATA_W  store data, right-aligned.
  ready  out  1  accepting requests.
  rdata  out  DATA_W  load result, right-aligned and extended.
  rvalid  out  1  one-cycle pulse; rdata is valid.
  err  out  1  one-cycle pulse; access rejected.

Function
REQ-005 SHALL map word address addr[ADDR_W+1:2] to bank = top log2(NBANKS) bits and row = remaining low bits.
REQ-006 SHALL accept a request when req and ready are both high at a rising edge.
REQ-007 SHALL commit an accepted store at that same edge, writing only the byte lanes selected by size and addr[1:0]; all other lanes are unchanged.
REQ-008 SHALL present load data registered: rdata/rvalid are asserted in the cycle after acceptance (latency 1), and rvalid is held for exactly one cycle.
REQ-009 SHALL place the selected bytes of a load at rdata[7:0] / [15:0] / [31:0], extending the upper bits per sign_ext.
REQ-010 SHALL treat a request as illegal when any of the following holds: half access with addr[0]=1; word access with addr[1:0]≠0; size=3.
REQ-011 SHALL, for an illegal request: write nothing, pulse err the cycle after acceptance, and keep rvalid low.
REQ-012 SHALL hold rdata at its last valid value when rvalid is low.
REQ-013 SHALL return the just-written value for a load accepted in the cycle immediately after a store to the same address, with no stall.
REQ-014 SHALL implement the FSM:
  CLEAR: ready=0; zero one row in every bank per cycle, row counter 0..rows-1; go to IDLE after the last row.
  IDLE: ready=1.
REQ-015 SHALL make the clear take exactly 2**ADDR_W/NBANKS cycles; default 256.
REQ-016 SHALL ignore req while in CLEAR; no err and no rvalid are produced.

Reset
REQ-017 SHALL on sys_rst_n low, asynchronously: enter CLEAR, set the row counter to 0, and set ready=0, rvalid=0, err=0, rdata=0.
REQ-018 SHALL, when reset is asserted mid-clear or mid-access, abandon that operation, restart the clear from row 0, and emit no rvalid for a pending load.
REQ-019 SHALL NOT reset memory contents asynchronously; contents are zeroed only by the CLEAR sequence.

Structure
REQ-020 SHALL take the size codes (BYTE/HALF/WORD), the FSM state encoding, and the lane-mask function from a shared package dmem_pkg.
REQ-021 SHALL instantiate NBANKS copies of one sub-module, dmem_bank: one row-addressed, byte-lane-write-enabled storage array with a registered read port.
REQ-022 SHALL keep the bank-select, alignment-check and extension logic in banked_dmem.

Verification
REQ-023 Reset, then count cycles -> ready rises exactly 256 cycles after sys_rst_n deasserts; a load from 0x3FC returns 0x00000000.
REQ-024 Word store 0x80FF7F01 @0x100, then byte loads @0x100..0x103 with sign_ext=1 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with sign_ext=0 the last two return 0x000000FF and 0x00000080.
REQ-025 Word store 0xAAAAAAAA @0x008, then half store 0x1234 @0x00A, then word load @0x008 -> 0x1234AAAA, returned 1 cycle after the load is accepted.
REQ-026 Back-to-back: store 0xDEADBEEF @0xFFC, then next-cycle load @0xFFC -> rvalid=1 with rdata=0xDEADBEEF; also bank 3, row 255 holds the value.
REQ-027 Illegal half load @0x001, word store @0x002 and size=3 -> err pulses once for each; memory is unchanged; rvalid stays 0.
REQ-028 Assert sys_rst_n low during CLEAR at row 100, and separately with a load in flight -> no rvalid; CLEAR restarts and ready rises 256 cycles after release.
